traffic_ctrl: RTL and testbench
===============================

Name: traffic_ctrl

Overview:
Traffic-light phase controller for a two-direction (NS/EW) crossing. It counts seconds from a 1 Hz enable pulse, sequences the four light phases, and drives the two light triplets. It also produces four BCD countdown digits that feed the 4-digit 7-segment display driver directly: fir/sec carry the NS tens/ones, thi/fou carry the EW tens/ones. Night mode and a freeze input are included.

Parameters:
GREEN_NS, 25, NS green duration in seconds (1..94)
GREEN_EW, 20, EW green duration in seconds (1..94)
YELLOW, 5, yellow duration in seconds for both directions (1..5); GREEN_x+YELLOW must be <= 99

Ports:
clk  input  1  system clock (12 MHz)
rst_n  input  1  asynchronous active-low reset
tick  input  1  one-clk-wide pulse once per second, synchronous to clk
hold  input  1  1 = freeze countdown; ticks ignored
night  input  1  1 = night mode (flashing yellow)
ns_light  output  3  NS lamps {red,yellow,green}, 1 = on
ew_light  output  3  EW lamps {red,yellow,green}, 1 = on
fir  output  4  BCD tens of NS remaining seconds
sec  output  4  BCD ones of NS remaining seconds
thi  output  4  BCD tens of EW remaining seconds
fou  output  4  BCD ones of EW remaining seconds

Behaviour:
- Reset is asynchronous and active-low: clk is the single clock, rst_n clears asynchronously.
- State register values: NS_G, NS_Y, EW_G, EW_Y, NIGHT. Phase counter cnt is 7 bits; blink is a 1-bit flag.
- Reset values: state=NS_G, cnt=GREEN_NS, blink=0, ns_light=001, ew_light=100. fir/sec = BCD(GREEN_NS), thi/fou = BCD(GREEN_NS+YELLOW). With defaults the digits are 2,5,3,0.
- Normal sequence: NS_G -> NS_Y -> EW_G -> EW_Y -> NS_G. Entering a phase loads cnt with that phase's duration.
- Tick handling, when hold=0 and night=0:
  - if cnt==1, advance to the next phase and load its duration;
  - otherwise cnt <= cnt-1.
  - cnt therefore takes the values DURATION..1 and never shows 0 in normal mode.
- Light decode (combinational from state, so lamps change on the same edge as state):
  - NS_G: ns=001, ew=100
  - NS_Y: ns=010, ew=100
  - EW_G: ns=100, ew=001
  - EW_Y: ns=100, ew=010
  - NIGHT: ns=ew={0,blink,0}
- Remaining seconds:
  - NS_G: ns_rem=cnt, ew_rem=cnt+YELLOW
  - NS_Y: ns_rem=ew_rem=cnt
  - EW_G: ew_rem=cnt, ns_rem=cnt+YELLOW
  - EW_Y: both = cnt
  - NIGHT: both = 0
- Digits are registered binary-to-BCD conversions of ns_rem/ew_rem (range 0..99). They update exactly one clk after the edge at which state or cnt changes. This one-cycle lag is the only latency in the block.
- hold=1: ticks are ignored, and state and cnt are frozen. If hold and tick are asserted in the same cycle, hold wins and that tick is lost. Night mode still takes effect during hold.
- night=1 (level, sampled every clk) has priority over tick and hold:
  - On the first cycle, state <= NIGHT and blink <= 1.
  - In NIGHT, each tick toggles blink.
  - When night falls to 0, the next edge sets state=NS_G, cnt=GREEN_NS, blink=0 (fresh start, no resume).
- If tick arrives on the same cycle night rises, it is not applied to cnt.
- rst_n asserted mid-phase, including in NIGHT, forces the reset values immediately, independent of clk.
- The block holds no other storage and has no handshake; tick is the sole timebase.

Test Plan:
- Params GREEN_NS=3, YELLOW=2, GREEN_EW=4; release reset with no tick -> lamps 001/100, digits 0,3,0,5 held indefinitely.
- Same params, tick every 10 clk for 11 ticks -> state NS_G(3,2,1) -> NS_Y(2,1) -> EW_G(4,3,2,1) -> EW_Y(2,1) -> NS_G. NS digits go 3,2,1,2,1,6,5,4,3,2,1,3. Lamps switch on the tick edge; digits follow 1 clk later.
- Default params, assert hold for 5 ticks at NS_G cnt=17, tick also pulsed on the same cycle hold rises -> digits stay 1,7 / 2,2. After release, the next tick gives 1,6 / 2,1.
- Default params, night=1 mid EW_G, then 4 ticks -> next edge lamps 010/010, digits 0,0,0,0 after 1 clk. Lamps toggle off/on/off/on per tick. Drop night -> 001/100 and 2,5,3,0.
- Drive rst_n low asynchronously between clk edges during EW_Y -> outputs return to reset values without waiting for a clk edge. Recovery starts at NS_G cnt=25.
- GREEN_NS=94, YELLOW=5 -> ew digits show 9,9 at reset. Check BCD conversion at 99, 10, 9 and 1 boundaries during the countdown.

Source files
------------

// File: rtl/traffic_ctrl.sv
// Traffic-light phase controller for an NS/EW crossing, with night mode, hold,
// and registered BCD countdown digits for a 4-digit seven-segment display.
module traffic_ctrl #(
    parameter int GREEN_NS = 25,
    parameter int GREEN_EW = 20,
    parameter int YELLOW   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       hold,
    input  logic       night,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [3:0] fir,
    output logic [3:0] sec,
    output logic [3:0] thi,
    output logic [3:0] fou
);

    typedef enum logic [2:0] {NS_G, NS_Y, EW_G, EW_Y, NIGHT} state_t;

    localparam logic [6:0] DUR_NS = 7'(GREEN_NS);
    localparam logic [6:0] DUR_EW = 7'(GREEN_EW);
    localparam logic [6:0] DUR_Y  = 7'(YELLOW);

    // Binary 0..99 to packed {tens,ones}; tens found by threshold comparison.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        tens = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            if (v >= 7'(i * 10)) tens = 4'(i);
        end
        return {tens, 4'(v - 7'(tens) * 7'd10)};
    endfunction

    localparam logic [7:0] RST_NS_BCD = to_bcd(DUR_NS);
    localparam logic [7:0] RST_EW_BCD = to_bcd(DUR_NS + DUR_Y);

    state_t     state, state_next;
    logic [6:0] cnt, cnt_next;
    logic       blink, blink_next;
    logic [6:0] ns_rem, ew_rem;
    logic [7:0] ns_bcd, ew_bcd;

    // Night overrides everything; leaving night restarts the cycle from NS green.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        blink_next = blink;
        if (night) begin
            if (state != NIGHT) begin
                state_next = NIGHT;
                blink_next = 1'b1;
            end else if (tick) begin
                blink_next = ~blink;
            end
        end else if (state == NIGHT) begin
            state_next = NS_G;
            cnt_next   = DUR_NS;
            blink_next = 1'b0;
        end else if (tick && !hold) begin
            if (cnt == 7'd1) begin
                case (state)
                    NS_G: begin state_next = NS_Y; cnt_next = DUR_Y;  end
                    NS_Y: begin state_next = EW_G; cnt_next = DUR_EW; end
                    EW_G: begin state_next = EW_Y; cnt_next = DUR_Y;  end
                    default: begin state_next = NS_G; cnt_next = DUR_NS; end
                endcase
            end else begin
                cnt_next = cnt - 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NS_G;
            cnt   <= DUR_NS;
            blink <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            blink <= blink_next;
        end
    end

    // The red direction waits for the other side's green plus yellow.
    always_comb begin
        ns_light = 3'b001;
        ew_light = 3'b100;
        ns_rem   = cnt;
        ew_rem   = cnt + DUR_Y;
        case (state)
            NS_Y: begin
                ns_light = 3'b010;
                ew_rem   = cnt;
            end
            EW_G: begin
                ns_light = 3'b100;
                ew_light = 3'b001;
                ew_rem   = cnt;
                ns_rem   = cnt + DUR_Y;
            end
            EW_Y: begin
                ns_light = 3'b100;
                ew_light = 3'b010;
                ew_rem   = cnt;
            end
            NIGHT: begin
                ns_light = {1'b0, blink, 1'b0};
                ew_light = {1'b0, blink, 1'b0};
                ns_rem   = 7'd0;
                ew_rem   = 7'd0;
            end
            default: ;
        endcase
    end

    assign ns_bcd = to_bcd(ns_rem);
    assign ew_bcd = to_bcd(ew_rem);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {fir, sec} <= RST_NS_BCD;
            {thi, fou} <= RST_EW_BCD;
        end else begin
            {fir, sec} <= ns_bcd;
            {thi, fou} <= ew_bcd;
        end
    end

endmodule

// File: tb/tb_traffic_ctrl.sv
// Bench for traffic_ctrl: three parameterisations share one stimulus stream and
// are compared every cycle against an elapsed-seconds reference model.
module tb_traffic_ctrl;

    logic clk = 1'b0;
    logic rst_n, tick, hold, night;
    logic [2:0] ns_l[3], ew_l[3];
    logic [3:0] fir[3], sec[3], thi[3], fou[3];

    int checks = 0;
    int errors = 0;

    int gns[3], gew[3], yel[3];
    int secs[3];
    bit in_night[3];
    bit blink[3];
    int exp_ns[3], exp_ew[3];

    always #5 clk = ~clk;

    traffic_ctrl u_def (
        .clk(clk), .rst_n(rst_n), .tick(tick), .hold(hold), .night(night),
        .ns_light(ns_l[0]), .ew_light(ew_l[0]),
        .fir(fir[0]), .sec(sec[0]), .thi(thi[0]), .fou(fou[0])
    );

    traffic_ctrl #(.GREEN_NS(3), .GREEN_EW(4), .YELLOW(2)) u_small (
        .clk(clk), .rst_n(rst_n), .tick(tick), .hold(hold), .night(night),
        .ns_light(ns_l[1]), .ew_light(ew_l[1]),
        .fir(fir[1]), .sec(sec[1]), .thi(thi[1]), .fou(fou[1])
    );

    traffic_ctrl #(.GREEN_NS(94), .GREEN_EW(20), .YELLOW(5)) u_big (
        .clk(clk), .rst_n(rst_n), .tick(tick), .hold(hold), .night(night),
        .ns_light(ns_l[2]), .ew_light(ew_l[2]),
        .fir(fir[2]), .sec(sec[2]), .thi(thi[2]), .fou(fou[2])
    );

    function automatic int period(int k);
        return gns[k] + yel[k] + gew[k] + yel[k];
    endfunction

    // Remaining seconds derived from position within the full light cycle.
    function automatic void remaining(int k, output int nr, output int er);
        int p, g1, y, g2;
        p = secs[k]; g1 = gns[k]; y = yel[k]; g2 = gew[k];
        if (in_night[k]) begin
            nr = 0; er = 0;
        end else if (p < g1) begin
            nr = g1 - p; er = g1 + y - p;
        end else if (p < g1 + y) begin
            nr = g1 + y - p; er = nr;
        end else if (p < g1 + y + g2) begin
            er = g1 + y + g2 - p; nr = er + y;
        end else begin
            nr = period(k) - p; er = nr;
        end
    endfunction

    function automatic void lamps(int k, output logic [2:0] ns, output logic [2:0] ew);
        int p;
        p = secs[k];
        if (in_night[k]) begin
            ns = {1'b0, blink[k], 1'b0}; ew = ns;
        end else if (p < gns[k]) begin
            ns = 3'b001; ew = 3'b100;
        end else if (p < gns[k] + yel[k]) begin
            ns = 3'b010; ew = 3'b100;
        end else if (p < gns[k] + yel[k] + gew[k]) begin
            ns = 3'b100; ew = 3'b001;
        end else begin
            ns = 3'b100; ew = 3'b010;
        end
    endfunction

    function automatic logic [15:0] bcd16(int nr, int er);
        return {4'(nr / 10), 4'(nr % 10), 4'(er / 10), 4'(er % 10)};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            secs[k] = 0; in_night[k] = 0; blink[k] = 0;
            remaining(k, exp_ns[k], exp_ew[k]);
        end
    endfunction

    function automatic void model_edge(bit t, bit h, bit n);
        for (int k = 0; k < 3; k++) begin
            remaining(k, exp_ns[k], exp_ew[k]);
            if (n) begin
                if (!in_night[k]) begin
                    in_night[k] = 1; blink[k] = 1;
                end else if (t) begin
                    blink[k] = ~blink[k];
                end
            end else if (in_night[k]) begin
                in_night[k] = 0; secs[k] = 0; blink[k] = 0;
            end else if (t && !h) begin
                secs[k] = (secs[k] + 1) % period(k);
            end
        end
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        logic [2:0] ens, eew;
        for (int k = 0; k < 3; k++) begin
            lamps(k, ens, eew);
            check($sformatf("ns_light[%0d]", k), {13'd0, ns_l[k]}, {13'd0, ens});
            check($sformatf("ew_light[%0d]", k), {13'd0, ew_l[k]}, {13'd0, eew});
            check($sformatf("digits[%0d]", k), {fir[k], sec[k], thi[k], fou[k]},
                  bcd16(exp_ns[k], exp_ew[k]));
        end
    endtask

    task automatic applyStimulus(input bit t, input bit h, input bit n);
        tick = t; hold = h; night = n;
        @(posedge clk);
        if (rst_n) model_edge(t, h, n);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic ticks(input int count, input int gap);
        for (int i = 0; i < count; i++) begin
            applyStimulus(1, 0, 0);
            for (int j = 1; j < gap; j++) applyStimulus(0, 0, 0);
        end
    endtask

    // Reset dropped between edges must take effect without a clock edge.
    task automatic async_reset();
        tick = 0; hold = 0; night = 0;
        #2 rst_n = 1'b0;
        #1 model_reset();
        checkOutput();
        check("async_rst_def_digits", {fir[0], sec[0], thi[0], fou[0]}, 16'h2530);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput();
    endtask

    int small_seq[12] = '{3, 2, 1, 2, 1, 6, 5, 4, 3, 2, 1, 3};
    bit night_lvl, hold_lvl;

    initial begin
        gns = '{25, 3, 94}; gew = '{20, 4, 20}; yel = '{5, 2, 5};
        rst_n = 1'b0; tick = 0; hold = 0; night = 0;
        model_reset();
        @(negedge clk);
        checkOutput();
        check("rst_def_digits", {fir[0], sec[0], thi[0], fou[0]}, 16'h2530);
        check("rst_small_digits", {fir[1], sec[1], thi[1], fou[1]}, 16'h0305);
        check("rst_big_digits", {fir[2], sec[2], thi[2], fou[2]}, 16'h9499);
        check("rst_ns_light", {13'd0, ns_l[0]}, 16'h0001);
        check("rst_ew_light", {13'd0, ew_l[0]}, 16'h0004);
        rst_n = 1'b1;

        // Idle without ticks: everything holds.
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0);
        check("idle_small_digits", {fir[1], sec[1], thi[1], fou[1]}, 16'h0305);

        // Small parameter set: NS countdown through a full cycle.
        for (int i = 0; i < 12; i++) begin
            check($sformatf("small_ns_seq%0d", i), {8'd0, fir[1], sec[1]},
                  {8'd0, 4'(small_seq[i] / 10), 4'(small_seq[i] % 10)});
            if (i < 11) ticks(1, 10);
        end

        // Hold at default cnt=17; tick coincides with hold rising and is lost.
        async_reset();
        ticks(8, 2);
        check("pre_hold_digits", {fir[0], sec[0], thi[0], fou[0]}, 16'h1722);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 0);
            applyStimulus(0, 1, 0);
        end
        check("hold_digits", {fir[0], sec[0], thi[0], fou[0]}, 16'h1722);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        check("post_hold_digits", {fir[0], sec[0], thi[0], fou[0]}, 16'h1621);

        // Night mode entered mid EW green, with a tick on the rising cycle.
        ticks(27, 2);
        applyStimulus(1, 0, 1);
        check("night_entry_ns", {13'd0, ns_l[0]}, 16'h0002);
        applyStimulus(0, 0, 1);
        check("night_digits", {fir[0], sec[0], thi[0], fou[0]}, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 1);
            applyStimulus(0, 0, 1);
        end
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        check("night_exit_digits", {fir[0], sec[0], thi[0], fou[0]}, 16'h2530);

        // Asynchronous reset during default EW yellow.
        ticks(52, 2);
        check("pre_reset_ew_y", {13'd0, ew_l[0]}, 16'h0002);
        async_reset();
        ticks(3, 2);

        // Large parameter set sweeps BCD boundaries 99, 10, 9, 1.
        async_reset();
        ticks(125, 2);

        // Randomized ticks, hold and night episodes.
        night_lvl = 0; hold_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) night_lvl = ~night_lvl;
            if ($urandom_range(0, 39) == 0) hold_lvl = ~hold_lvl;
            applyStimulus($urandom_range(0, 3) == 0, hold_lvl, night_lvl);
        end
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
